lzrw1_item_parser: RTL
======================

// Module: lzrw1_item_parser
// PURPOSE
//  Downstream consumer of the decompressor input byte FIFO. Pops compressed bytes and decodes LZRW1 framing:
//  16-bit little-endian control word, then 16 items (flag bit0 first). Flag 0 = literal (1 byte); flag 1 = copy
//  (2 bytes). Emits one token per item over valid/ready to the history/copy engine.
// PARAMETERS
//  BYTE_CNT_WIDTH  16  width of compressed-byte count for one stream
// PORTS
//  clk              in   1               clock
//  reset            in   1               synchronous, active-high reset
//  start_in         in   1               pulse: begin stream, latch byte_count_in
//  byte_count_in    in   BYTE_CNT_WIDTH  compressed bytes in this stream
//  fifo_data_in     in   8               FIFO head byte (show-ahead, valid when !fifo_empty_in)
//  fifo_empty_in    in   1               FIFO empty
//  fifo_rd_en_out   out  1               pop FIFO head this cycle
//  tok_valid_out    out  1               token valid
//  tok_ready_in     in   1               downstream accepts token
//  tok_is_copy_out  out  1               1 = copy token, 0 = literal
//  tok_literal_out  out  8               literal byte
//  tok_offset_out   out  12              copy offset, 1..4095
//  tok_len_out      out  5               copy length, 3..16
//  busy_out         out  1               stream in progress
//  done_out         out  1               1-cycle pulse at end of stream
//  err_out          out  1               sticky error; cleared by start_in
// BEHAVIOUR
//  - Everything is synchronous to clk, with a synchronous active-high reset.
//  - Reset: state=IDLE. All outputs are 0.
//  - Reset mid-stream aborts with no further pops. fifo_rd_en_out is forced 0 while reset=1.
//  - FSM: IDLE -> CTRL_LO -> CTRL_HI -> ITEM0 -> [ITEM1] -> EMIT -> {ITEM0 | CTRL_LO | DONE} -> IDLE.
//  - Read states are CTRL_LO, CTRL_HI, ITEM0 and ITEM1.
//    - fifo_rd_en_out = read_state & !fifo_empty_in & bytes_left!=0 (combinational).
//    - On a pop: capture fifo_data_in, decrement bytes_left, advance.
//    - FIFO empty stalls the state with no pop.
//  - IDLE: start_in latches bytes_left=byte_count_in, clears err_out, and moves to CTRL_LO.
//    byte_count_in==0 goes to DONE instead.
//  - start_in while busy_out=1 is ignored.
//  - CTRL_LO / CTRL_HI: ctrl[7:0] then ctrl[15:8]; flags_left=16.
//  - ITEM0: pop byte b0.
//    - ctrl[0]=0: literal=b0 -> EMIT.
//    - ctrl[0]=1 -> ITEM1.
//  - ITEM1: pop b1.
//    - offset = {b0[7:4], b1}; len = b0[3:0]+1 (5-bit add, no wrap).
//    - -> EMIT.
//  - EMIT: tok_valid_out=1, token fields held stable until tok_ready_in.
//    - On handshake: ctrl>>=1, flags_left-=1.
//    - Next state: bytes_left==0 -> DONE; else flags_left==0 -> CTRL_LO; else ITEM0.
//  - Latency: token valid the cycle after its last byte is popped. Minimum 2 cycles per literal, 3 per copy.
//  - Truncation error: a read is required in CTRL_HI or ITEM1 but bytes_left==0.
//    - Sets err_out and goes to DONE. No token is emitted.
//  - A stream may end with unused flag bits; this is not an error.
//  - DONE: done_out=1 for one cycle -> IDLE. busy_out=1 in every state except IDLE.
//  - Fields not selected by tok_is_copy_out are 0.
// CONFIGURATION
//  - LZRW1_OFFSET_CHECK_EN defined:
//    - An 18-bit out_bytes counter adds 1 per literal and len per copy, cleared at start_in.
//    - A copy with offset==0 or offset>out_bytes sets err_out.
//    - The token is still emitted; the stream continues.
//  - LZRW1_OFFSET_CHECK_EN undefined: no counter, no offset check. err_out reflects truncation only.
// STRUCTURE
//  - lzrw1_pkg holds:
//    - parser_state_t enum;
//    - OFFSET_WIDTH=12, LEN_WIDTH=5, FLAGS_PER_CTRL=16, MIN_COPY_LEN=3;
//    - token_t struct {is_copy, literal, offset, len}.
//  - Single module; no sub-module (FSM plus counters only).
// TESTING
//  - count=5, bytes 02 00 41 02 01 -> literal 0x41, then copy offset=0x001 len=3; done pulse, err=0.
//  - count=21: ctrl 00 00, 16 literals 0x00..0x0F, ctrl 00 00, literal 0xAA -> 17 literals in order.
//    Check the 2nd control word is read after the 16th item.
//  - tok_ready_in low 5 cycles during EMIT -> token stable, fifo_rd_en_out=0, no pops.
//  - FIFO empty for 4 cycles between b0 and b1 of a copy -> stall, then correct single copy token.
//  - count=3, bytes 01 00 12 -> no token, err_out=1, done pulse; next start_in clears err_out.
//  - Reset asserted in ITEM1 -> next cycle IDLE, all outputs 0, no pop; new stream then decodes correctly.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 item parser.
// Optional offset validation is enabled with the LZRW1_OFFSET_CHECK_EN macro (see lzrw1_item_parser).
package lzrw1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL_LO,
    ST_CTRL_HI,
    ST_ITEM0,
    ST_ITEM1,
    ST_EMIT,
    ST_DONE
  } parser_state_t;

  localparam int OFFSET_WIDTH   = 12;
  localparam int LEN_WIDTH      = 5;
  localparam int FLAGS_PER_CTRL = 16;
  localparam int MIN_COPY_LEN   = 3;

  typedef struct packed {
    logic                    is_copy;
    logic [7:0]              literal;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [LEN_WIDTH-1:0]    len;
  } token_t;

  // Copy length is the low nibble of the first copy byte plus one, widened so 15+1 does not wrap.
  function automatic logic [LEN_WIDTH-1:0] copy_len(input logic [3:0] nibble);
    return {1'b0, nibble} + LEN_WIDTH'(1);
  endfunction

endpackage

// File: rtl/lzrw1_item_parser.sv
// LZRW1 framing decoder: pops compressed bytes from a show-ahead FIFO and emits one literal/copy token per item.
// Define LZRW1_OFFSET_CHECK_EN to flag copies whose offset reaches past the bytes produced so far.
module lzrw1_item_parser
  import lzrw1_pkg::*;
#(
  parameter int BYTE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_in,
  input  logic [BYTE_CNT_WIDTH-1:0] byte_count_in,
  input  logic [7:0]                fifo_data_in,
  input  logic                      fifo_empty_in,
  output logic                      fifo_rd_en_out,
  output logic                      tok_valid_out,
  input  logic                      tok_ready_in,
  output logic                      tok_is_copy_out,
  output logic [7:0]                tok_literal_out,
  output logic [OFFSET_WIDTH-1:0]   tok_offset_out,
  output logic [LEN_WIDTH-1:0]      tok_len_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      err_out
);

  parser_state_t             state_reg;
  logic [BYTE_CNT_WIDTH-1:0] bytes_left_reg;
  logic [15:0]               ctrl_reg;
  logic [4:0]                flags_left_reg;
  logic [7:0]                b0_reg;
  token_t                    tok_reg;
  logic                      err_reg;

  logic                      read_state;
  logic                      bytes_avail;
  logic                      pop;
  logic [OFFSET_WIDTH-1:0]   copy_off;

`ifdef LZRW1_OFFSET_CHECK_EN
  logic [17:0]               out_bytes_reg;
`endif

  assign read_state  = (state_reg == ST_CTRL_LO) || (state_reg == ST_CTRL_HI) ||
                       (state_reg == ST_ITEM0)   || (state_reg == ST_ITEM1);
  assign bytes_avail = (bytes_left_reg != '0);
  assign pop         = !reset && read_state && !fifo_empty_in && bytes_avail;
  assign copy_off    = {b0_reg[7:4], fifo_data_in};

  assign fifo_rd_en_out  = pop;
  assign tok_valid_out   = (state_reg == ST_EMIT);
  assign busy_out        = (state_reg != ST_IDLE);
  assign done_out        = (state_reg == ST_DONE);
  assign err_out         = err_reg;
  assign tok_is_copy_out = tok_reg.is_copy;
  assign tok_literal_out = tok_reg.literal;
  assign tok_offset_out  = tok_reg.offset;
  assign tok_len_out     = tok_reg.len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      bytes_left_reg <= '0;
      ctrl_reg       <= '0;
      flags_left_reg <= '0;
      b0_reg         <= '0;
      tok_reg        <= '0;
      err_reg        <= 1'b0;
`ifdef LZRW1_OFFSET_CHECK_EN
      out_bytes_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_in) begin
            bytes_left_reg <= byte_count_in;
            err_reg        <= 1'b0;
`ifdef LZRW1_OFFSET_CHECK_EN
            out_bytes_reg  <= '0;
`endif
            state_reg      <= (byte_count_in == '0) ? ST_DONE : ST_CTRL_LO;
          end
        end

        ST_CTRL_LO: begin
          if (!bytes_avail) begin
            state_reg <= ST_DONE;
          end else if (pop) begin
            ctrl_reg[7:0]  <= fifo_data_in;
            bytes_left_reg <= bytes_left_reg - 1'b1;
            state_reg      <= ST_CTRL_HI;
          end
        end

        ST_CTRL_HI: begin
          if (!bytes_avail) begin
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else if (pop) begin
            ctrl_reg[15:8] <= fifo_data_in;
            flags_left_reg <= 5'(FLAGS_PER_CTRL);
            bytes_left_reg <= bytes_left_reg - 1'b1;
            state_reg      <= ST_ITEM0;
          end
        end

        // Running out of bytes at an item boundary just leaves flag bits unused.
        ST_ITEM0: begin
          if (!bytes_avail) begin
            state_reg <= ST_DONE;
          end else if (pop) begin
            b0_reg         <= fifo_data_in;
            bytes_left_reg <= bytes_left_reg - 1'b1;
            if (ctrl_reg[0]) begin
              state_reg <= ST_ITEM1;
            end else begin
              tok_reg   <= '{is_copy: 1'b0, literal: fifo_data_in, offset: '0, len: '0};
              state_reg <= ST_EMIT;
            end
          end
        end

        ST_ITEM1: begin
          if (!bytes_avail) begin
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else if (pop) begin
            bytes_left_reg <= bytes_left_reg - 1'b1;
            tok_reg        <= '{is_copy: 1'b1, literal: '0, offset: copy_off,
                                len: copy_len(b0_reg[3:0])};
`ifdef LZRW1_OFFSET_CHECK_EN
            if ((copy_off == '0) || ({6'd0, copy_off} > out_bytes_reg)) err_reg <= 1'b1;
`endif
            state_reg      <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (tok_ready_in) begin
            ctrl_reg       <= {1'b0, ctrl_reg[15:1]};
            flags_left_reg <= flags_left_reg - 1'b1;
`ifdef LZRW1_OFFSET_CHECK_EN
            out_bytes_reg  <= out_bytes_reg + (tok_reg.is_copy ? 18'(tok_reg.len) : 18'd1);
`endif
            if (!bytes_avail)              state_reg <= ST_DONE;
            else if (flags_left_reg == 5'd1) state_reg <= ST_CTRL_LO;
            else                           state_reg <= ST_ITEM0;
          end
        end

        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
